// File: rtl/sobel_edge_stream_if.sv
// Pixel and result stream bundles for the Sobel edge detector.
// Each carries a valid strobe and a start-of-frame marker.
interface pix_stream_if #(
    parameter int DATA_W = 8
);
    logic              valid;
    logic              sof;
    logic [DATA_W-1:0] data;

    modport master (output valid, output sof, output data);
    modport slave  (input  valid, input  sof, input  data);
endinterface

interface result_stream_if #(
    parameter int MAG_W = 11
);
    logic             valid;
    logic             sof;
    logic [MAG_W-1:0] mag;
    logic             bin;
    logic [15:0]      data;

    modport master (output valid, output sof, output mag,
                    output bin, output data);
    modport slave  (input  valid, input  sof, input  mag,
                    input  bin, input  data);
endinterface

// File: rtl/sobel_edge_stream.sv
// Streaming 3x3 Sobel edge detector: two line buffers, window,
// gradient magnitude (L1 or max), threshold to binary / RGB565.
module sobel_edge_stream #(
    parameter  int DATA_W = 8,
    parameter  int IMG_W  = 640,
    parameter  int IMG_H  = 480,
    localparam int MAG_W  = DATA_W + 3
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    pix_stream_if.slave       pixel,
    result_stream_if.master   result,
    input  logic [MAG_W-1:0]  thr,
    input  logic              mode
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int SW = DATA_W + 2;

    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;

    // A start-of-frame pixel is placed at (0,0) regardless of counters
    assign cur_col = pixel.sof ? '0 : col;
    assign cur_row = pixel.sof ? '0 : row;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            col <= '0;
            row <= '0;
        end else if (pixel.valid) begin
            if (cur_col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= (cur_row == RW'(IMG_H - 1)) ? '0
                     : cur_row + RW'(1);
            end else begin
                col <= cur_col + CW'(1);
                row <= cur_row;
            end
        end
    end

    logic [DATA_W-1:0] lb0 [IMG_W];
    logic [DATA_W-1:0] lb1 [IMG_W];
    logic [DATA_W-1:0] lb0_rd, lb1_rd;

    assign lb0_rd = lb0[cur_col];
    assign lb1_rd = lb1[cur_col];

    // Line buffers are never cleared; border masking hides stale data
    always_ff @(posedge sys_clk) begin
        if (pixel.valid) begin
            lb0[cur_col] <= pixel.data;
            lb1[cur_col] <= lb0_rd;
        end
    end

    logic [DATA_W-1:0] w [3][3];
    logic              v1, sof1, bd1;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3; j++)
                    w[i][j] <= '0;
            v1   <= 1'b0;
            sof1 <= 1'b0;
            bd1  <= 1'b1;
        end else begin
            v1   <= pixel.valid;
            sof1 <= pixel.valid & pixel.sof;
            if (pixel.valid) begin
                for (int i = 0; i < 3; i++) begin
                    w[i][0] <= w[i][1];
                    w[i][1] <= w[i][2];
                end
                w[0][2] <= lb1_rd;
                w[1][2] <= lb0_rd;
                w[2][2] <= pixel.data;
                bd1 <= (cur_row < RW'(2)) | (cur_col < CW'(2));
            end
        end
    end

    logic [SW-1:0]    sx_r, sx_l, sy_t, sy_b;
    logic signed [SW:0] gx, gy;
    logic [SW-1:0]    ax, ay;
    logic [MAG_W-1:0] mag_c;

    always_comb begin
        sx_r = SW'(w[0][2]) + (SW'(w[1][2]) << 1) + SW'(w[2][2]);
        sx_l = SW'(w[0][0]) + (SW'(w[1][0]) << 1) + SW'(w[2][0]);
        sy_t = SW'(w[0][0]) + (SW'(w[0][1]) << 1) + SW'(w[0][2]);
        sy_b = SW'(w[2][0]) + (SW'(w[2][1]) << 1) + SW'(w[2][2]);
        gx   = $signed({1'b0, sx_r}) - $signed({1'b0, sx_l});
        gy   = $signed({1'b0, sy_t}) - $signed({1'b0, sy_b});
        ax   = gx[SW] ? SW'(-gx) : SW'(gx);
        ay   = gy[SW] ? SW'(-gy) : SW'(gy);
        if (mode)
            mag_c = (ax > ay) ? MAG_W'(ax) : MAG_W'(ay);
        else
            mag_c = MAG_W'(ax) + MAG_W'(ay);
    end

    logic             v2, sof2, bd2;
    logic [MAG_W-1:0] mag2;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            v2   <= 1'b0;
            sof2 <= 1'b0;
            bd2  <= 1'b1;
            mag2 <= '0;
        end else begin
            v2   <= v1;
            sof2 <= v1 & sof1;
            if (v1) begin
                bd2  <= bd1;
                mag2 <= mag_c;
            end
        end
    end

    logic             o_valid, o_sof, o_bin;
    logic [MAG_W-1:0] o_mag;
    logic [15:0]      o_data;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            o_valid <= 1'b0;
            o_sof   <= 1'b0;
            o_mag   <= '0;
            o_bin   <= 1'b1;
            o_data  <= 16'hFFFF;
        end else begin
            o_valid <= v2;
            o_sof   <= v2 & sof2;
            if (v2) begin
                if (bd2) begin
                    o_mag  <= '0;
                    o_bin  <= 1'b1;
                    o_data <= 16'hFFFF;
                end else begin
                    o_mag  <= mag2;
                    o_bin  <= ~(mag2 >= thr);
                    o_data <= (mag2 >= thr) ? 16'h0000 : 16'hFFFF;
                end
            end
        end
    end

    assign result.valid = o_valid;
    assign result.sof   = o_sof;
    assign result.mag   = o_mag;
    assign result.bin   = o_bin;
    assign result.data  = o_data;
endmodule

// File: tb/tb_sobel_edge_stream.sv
// Directed bench for sobel_edge_stream on an 8x6 frame with
// a frame-level expectation queue and hand-picked spot values.
module tb_sobel_edge_stream;
    localparam int DW = 8;
    localparam int W  = 8;
    localparam int H  = 6;
    localparam int MW = DW + 3;

    logic          sys_clk   = 1'b0;
    logic          sys_rst_n = 1'b1;
    logic [MW-1:0] thr;
    logic          mode;

    pix_stream_if    #(.DATA_W(DW)) pix ();
    result_stream_if #(.MAG_W(MW))  res ();

    sobel_edge_stream #(
        .DATA_W (DW),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .pixel     (pix),
        .result    (res),
        .thr       (thr),
        .mode      (mode)
    );

    always #5 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int r, c, sof, mag, bin, cyc;
    } exp_t;

    exp_t q[$];
    int   img     [H][W];
    int   got_mag [H][W];
    int   got_bin [H][W];
    logic [4:0] gp = 5'b11001;

    task automatic set_img(input int kind);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (kind)
                    0:       img[r][c] = 100;
                    1:       img[r][c] = (c >= 4) ? 255 : 0;
                    default: img[r][c] = (r == 2 && c == 4) ? 255 : 0;
                endcase
    endtask

    task automatic clr_got();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                got_mag[r][c] = -1;
                got_bin[r][c] = -1;
            end
    endtask

    function automatic int model_mag(input int r, input int c,
                                     input logic md);
        int gx, gy;
        if (r < 2 || c < 2) return 0;
        gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
           - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
        gy = (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c])
           - (img[r][c-2] + 2*img[r][c-1] + img[r][c]);
        if (gx < 0) gx = -gx;
        if (gy < 0) gy = -gy;
        return md ? ((gx > gy) ? gx : gy) : gx + gy;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            #1;
            pix.valid = 1'b0;
            pix.sof   = 1'b0;
        end
    endtask

    task automatic drive_px(input int r, input int c, input bit sof);
        exp_t e;
        @(posedge sys_clk);
        #1;
        pix.valid = 1'b1;
        pix.sof   = sof;
        pix.data  = DW'(img[r][c]);
        e.r   = r;
        e.c   = c;
        e.sof = int'(sof);
        e.mag = model_mag(r, c, mode);
        e.bin = (r < 2 || c < 2) ? 1 : ((e.mag >= int'(thr)) ? 0 : 1);
        e.cyc = cyc;
        q.push_back(e);
    endtask

    task automatic feed(input int n_px, input bit sof0, input bit gaps);
        int k = 0;
        int n = 0;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                if (n < n_px) begin
                    if (gaps)
                        while (!gp[k]) begin
                            idle(1);
                            k = (k + 1) % 5;
                        end
                    drive_px(r, c, sof0 && n == 0);
                    if (gaps) k = (k + 1) % 5;
                    n++;
                end
    endtask

    task automatic drain();
        idle(6);
        check("drain", q.size(), 0);
    endtask

    int   last_mag = 0;
    exp_t em;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            last_mag = 0;
        end else begin
            if (res.valid) begin
                if (q.size() == 0) begin
                    check("spurious", 1, 0);
                end else begin
                    em = q.pop_front();
                    check("lat", cyc - em.cyc, 3);
                    check("sof", int'(res.sof), em.sof);
                    check("mag", int'(res.mag), em.mag);
                    check("bin", int'(res.bin), em.bin);
                    check("data", int'(res.data),
                          em.bin ? 32'hFFFF : 0);
                    got_mag[em.r][em.c] = int'(res.mag);
                    got_bin[em.r][em.c] = int'(res.bin);
                end
            end else begin
                if (q.size() > 0 && cyc >= q[0].cyc + 3) begin
                    check("missing", 0, 1);
                    void'(q.pop_front());
                end
                check("hold", int'(res.mag), last_mag);
            end
            last_mag = int'(res.mag);
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        pix.valid = 1'b0;
        pix.sof   = 1'b0;
        pix.data  = '0;
        thr  = MW'(1);
        mode = 1'b0;
        #1 sys_rst_n = 1'b0;
        #11;
        check("rst_valid", int'(res.valid), 0);
        check("rst_sof", int'(res.sof), 0);
        check("rst_mag", int'(res.mag), 0);
        check("rst_bin", int'(res.bin), 1);
        check("rst_data", int'(res.data), 32'hFFFF);
        #1 sys_rst_n = 1'b1;

        // flat field
        set_img(0);
        clr_got();
        feed(W*H, 1'b1, 1'b0);
        drain();
        check("flat_mag", got_mag[3][3], 0);
        check("flat_bin", got_bin[3][3], 1);

        // vertical step
        set_img(1);
        thr = MW'(27);
        clr_got();
        feed(W*H, 1'b1, 1'b0);
        drain();
        check("step_c3", got_mag[2][4], 1020);
        check("step_c4", got_mag[2][5], 1020);
        check("step_c5", got_mag[2][6], 0);
        check("step_c2", got_mag[2][3], 0);
        check("step_bin", got_bin[2][4], 0);

        // point impulse, L1 then max
        set_img(2);
        thr = MW'(100);
        clr_got();
        feed(W*H, 1'b1, 1'b0);
        drain();
        check("imp_l1", got_mag[2][4], 510);
        mode = 1'b1;
        clr_got();
        feed(W*H, 1'b1, 1'b0);
        drain();
        check("imp_max", got_mag[2][4], 255);
        mode = 1'b0;

        // gaps 1,0,0,1,1
        set_img(1);
        thr = MW'(27);
        clr_got();
        feed(W*H, 1'b1, 1'b1);
        drain();
        check("gap_c3", got_mag[3][4], 1020);

        // reset after pixel (3,5)
        feed(3*W + 6, 1'b1, 1'b0);
        @(posedge sys_clk);
        #1;
        pix.valid = 1'b0;
        pix.sof   = 1'b0;
        sys_rst_n = 1'b0;
        #1;
        check("mrst_valid", int'(res.valid), 0);
        check("mrst_mag", int'(res.mag), 0);
        check("mrst_bin", int'(res.bin), 1);
        check("mrst_data", int'(res.data), 32'hFFFF);
        q.delete();
        repeat (2) @(posedge sys_clk);
        #3 sys_rst_n = 1'b1;
        clr_got();
        feed(W*H, 1'b0, 1'b0);
        drain();
        check("mrst_r1_mag", got_mag[1][4], 0);
        check("mrst_r1_bin", got_bin[1][4], 1);
        check("mrst_r2_mag", got_mag[2][4], 1020);

        // in_sof arriving at (4,2)
        feed(4*W + 2, 1'b1, 1'b0);
        clr_got();
        feed(W*H, 1'b1, 1'b0);
        drain();
        check("msof_r1_mag", got_mag[1][5], 0);
        check("msof_r1_bin", got_bin[1][5], 1);
        check("msof_r2_mag", got_mag[2][5], 1020);
        check("msof_r2_bin", got_bin[2][5], 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
